// File: rtl/grf_scoreboard.sv
// General register file with write-to-read bypass, per-register pending-write
// counters for hazard detection, and a registered one-cycle write-trace port.
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [31:0]       wr_pc,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              trace_valid,
  output logic [31:0]       trace_pc,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic              ovf_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [PEND_W-1:0] cnt_q  [DEPTH];
  logic [PEND_W-1:0] cnt_d  [DEPTH];

  logic              trace_valid_q, trace_valid_d;
  logic [31:0]       trace_pc_q, trace_pc_d;
  logic [ADDR_W-1:0] trace_addr_q, trace_addr_d;
  logic [DATA_W-1:0] trace_data_q, trace_data_d;
  logic              ovf_q, ovf_d;

  logic rsv_hit;
  logic wr_dec;

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;

    rsv_hit = rsv && (rsv_addr != '0);
    wr_dec  = we && (wr_addr != '0) && (cnt_q[wr_addr] != '0);

    if (we && (wr_addr != '0)) begin
      regs_d[wr_addr] = wr_data;
    end

    // A reservation and a retiring write to the same register cancel out;
    // this also keeps a saturated counter from raising a false overflow.
    if (!(rsv_hit && wr_dec && (rsv_addr == wr_addr))) begin
      if (rsv_hit) begin
        if (cnt_q[rsv_addr] == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[rsv_addr] = cnt_q[rsv_addr] + CNT_ONE;
        end
      end
      if (wr_dec) begin
        cnt_d[wr_addr] = cnt_q[wr_addr] - CNT_ONE;
      end
    end
  end

  always_comb begin
    trace_valid_d = we;
    trace_pc_d    = trace_pc_q;
    trace_addr_d  = trace_addr_q;
    trace_data_d  = trace_data_q;
    if (we) begin
      trace_pc_d   = wr_pc;
      trace_addr_d = wr_addr;
      trace_data_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
      ovf_q         <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      cnt_q         <= cnt_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
      ovf_q         <= ovf_d;
    end
  end

  // Busy deliberately ignores a same-cycle write; it drops on the next cycle.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd_addr1 != '0) begin
      if ((BYPASS != 0) && we && (wr_addr == rd_addr1)) rd_data1 = wr_data;
      else                                              rd_data1 = regs_q[rd_addr1];
    end
    if (rd_addr2 != '0) begin
      if ((BYPASS != 0) && we && (wr_addr == rd_addr2)) rd_data2 = wr_data;
      else                                              rd_data2 = regs_q[rd_addr2];
    end
    rd_busy1 = (rd_addr1 != '0) && (cnt_q[rd_addr1] != '0);
    rd_busy2 = (rd_addr2 != '0) && (cnt_q[rd_addr2] != '0);
  end

  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Scoreboard bench for grf_scoreboard: stimulus queues expected read/trace
// results, a negedge monitor pops and compares them.
module tb_grf_scoreboard;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_busy1, rd_busy2;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] wr_pc;
  logic        rsv;
  logic [4:0]  rsv_addr;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic        ovf_err;

  grf_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .PEND_W(2)) dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
    .rsv(rsv), .rsv_addr(rsv_addr),
    .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_addr(trace_addr), .trace_data(trace_data),
    .ovf_err(ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        tv;
    logic        ovf;
    logic        tz;
  } rd_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } tr_exp_t;

  rd_exp_t rd_q[$];
  tr_exp_t tr_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: trace port first, then the queued read-side snapshot.
  initial begin
    rd_exp_t e;
    tr_exp_t t;
    forever begin
      @(negedge clk);
      if (trace_valid === 1'b1) begin
        if (tr_q.size() == 0) begin
          chk("trace_unexpected", 32'd1, 32'd0);
        end else begin
          t = tr_q.pop_front();
          chk("trace_pc", trace_pc, t.pc);
          chk("trace_addr", {27'd0, trace_addr}, {27'd0, t.addr});
          chk("trace_data", trace_data, t.data);
        end
      end
      if (rd_q.size() != 0) begin
        e = rd_q.pop_front();
        chk({e.name, ".rd_data1"}, rd_data1, e.d1);
        chk({e.name, ".rd_data2"}, rd_data2, e.d2);
        chk({e.name, ".rd_busy1"}, {31'd0, rd_busy1}, {31'd0, e.b1});
        chk({e.name, ".rd_busy2"}, {31'd0, rd_busy2}, {31'd0, e.b2});
        chk({e.name, ".trace_valid"}, {31'd0, trace_valid}, {31'd0, e.tv});
        chk({e.name, ".ovf_err"}, {31'd0, ovf_err}, {31'd0, e.ovf});
        if (e.tz) begin
          chk({e.name, ".trace_pc0"}, trace_pc, 32'd0);
          chk({e.name, ".trace_addr0"}, {27'd0, trace_addr}, 32'd0);
          chk({e.name, ".trace_data0"}, trace_data, 32'd0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] pc, input logic r, input logic [4:0] ra,
                       input logic [4:0] a1, input logic [4:0] a2);
    we = w; wr_addr = wa; wr_data = wd; wr_pc = pc;
    rsv = r; rsv_addr = ra; rd_addr1 = a1; rd_addr2 = a2;
    if (w) tr_q.push_back('{pc: pc, addr: wa, data: wd});
  endtask

  task automatic expect_rd(input string name, input logic [31:0] d1, input logic [31:0] d2,
                           input logic b1, input logic b2, input logic tv,
                           input logic ovf, input logic tz);
    rd_q.push_back('{name: name, d1: d1, d2: d2, b1: b1, b2: b2, tv: tv, ovf: ovf, tz: tz});
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    reset = 1'b1;

    drive(0, 0, 0, 0, 0, 0, 5, 0);
    expect_rd("reset_read", 0, 0, 0, 0, 0, 0, 1);
    cyc();

    drive(1, 3, 32'hDEADBEEF, 32'h100, 0, 0, 3, 0);
    expect_rd("bypass", 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 3, 0);
    expect_rd("readback", 32'hDEADBEEF, 0, 0, 0, 1, 0, 0);
    cyc();

    drive(1, 0, 32'h12345678, 32'h104, 1, 0, 0, 3);
    expect_rd("reg0_write", 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    expect_rd("reg0_after", 0, 0, 0, 0, 1, 0, 0);
    cyc();

    drive(0, 0, 0, 0, 1, 7, 7, 0);
    expect_rd("rsv7_first", 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 1, 7, 7, 0);
    expect_rd("rsv7_second", 0, 0, 1, 0, 0, 0, 0);
    cyc();
    drive(1, 7, 32'hA5A50007, 32'h108, 0, 0, 7, 0);
    expect_rd("wr7_first", 32'hA5A50007, 0, 1, 0, 0, 0, 0);
    cyc();
    drive(1, 7, 32'h00000777, 32'h10C, 0, 0, 7, 0);
    expect_rd("wr7_still_busy", 32'h00000777, 0, 1, 0, 1, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 7, 0);
    expect_rd("busy7_clear", 32'h00000777, 0, 0, 0, 1, 0, 0);
    cyc();

    drive(0, 0, 0, 0, 1, 7, 7, 0);
    expect_rd("rsv7_again", 32'h00000777, 0, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 7, 32'h00001234, 32'h110, 1, 7, 7, 0);
    expect_rd("rsv_we_same_cnt1", 32'h00001234, 0, 1, 0, 0, 0, 0);
    cyc();
    drive(1, 8, 32'h00000088, 32'h114, 1, 8, 7, 8);
    expect_rd("rsv_we_same_cnt0", 32'h00001234, 32'h00000088, 1, 0, 1, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 7, 8);
    expect_rd("net_counts", 32'h00001234, 32'h00000088, 1, 1, 1, 0, 0);
    cyc();

    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 9, 9, 0);
      expect_rd($sformatf("sat_rsv%0d", i), 0, 0, (i != 0), 0, 0, 0, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 9, 0);
    expect_rd("sat_ovf", 0, 0, 1, 0, 0, 1, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, 9, 32'h900 + i, 32'h200 + 4 * i, 0, 0, 9, 0);
      expect_rd($sformatf("sat_wr%0d", i), 32'h900 + i, 0, 1, 0, (i != 0), 1, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 9, 0);
    expect_rd("sat_drained", 32'h902, 0, 0, 0, 1, 1, 0);
    cyc();

    drive(0, 0, 0, 0, 0, 0, 3, 7);
    #1;
    reset = 1'b0;
    expect_rd("async_reset", 0, 0, 0, 0, 0, 0, 1);
    cyc();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 3, 8);
    expect_rd("after_reset", 0, 0, 0, 0, 0, 0, 1);
    cyc();
    cyc();

    tests++;
    if (tr_q.size() != 0 || rd_q.size() != 0) begin
      fails++;
      $display("FAIL queues_drained: trace left %0d read left %0d, required 0 and 0",
               tr_q.size(), rd_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Parametrised general register file for the pipelined CPU; successor to the single-write, unbypassed GRF.
- Adds configurable data width and depth, write-to-read bypass and a per-register pending-write scoreboard for hazard detection.
- Replaces the simulation-only write print with a registered write-trace port.
- Sits between the decode stage (reads, issue reservations) and the writeback stage (writes).

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored values only.
- PEND_W, 2, width of each per-register pending-write counter; max count = 2**PEND_W-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data, combinational.
- rd_data2  out  DATA_W  read port 2 data, combinational.
- rd_busy1  out  1  pending write exists for rd_addr1.
- rd_busy2  out  1  pending write exists for rd_addr2.
- we  in  1  writeback write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_pc  in  32  PC of the writing instruction, used for trace.
- rsv  in  1  issue reservation: a future write to rsv_addr is in flight.
- rsv_addr  in  ADDR_W  reserved destination.
- trace_valid  out  1  a write was accepted last cycle.
- trace_pc  out  32  PC of the traced write.
- trace_addr  out  ADDR_W  address of the traced write.
- trace_data  out  DATA_W  data of the traced write.
- ovf_err  out  1  sticky flag: reservation dropped because the counter was saturated.

Behaviour:
- Reset (reset==0, async):
  - All registers = 0; all pending counters = 0.
  - trace_valid = 0; trace_pc, trace_addr, trace_data = 0; ovf_err = 0.
  - Reset mid-operation discards all in-flight reservations and writes.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to it are not stored, but are still traced.
  - Reservations to it are ignored.
- Write:
  - When we==1 at a rising edge and wr_addr!=0, reg[wr_addr] <= wr_data.
- Read:
  - Combinational. rd_dataN = reg[rd_addrN], or 0 when rd_addrN==0.
  - If BYPASS==1, we==1, wr_addr==rd_addrN and rd_addrN!=0, then rd_dataN = wr_data (same-cycle forwarding).
- Scoreboard: one counter per register, cnt[a].
  - rsv==1, rsv_addr!=0: increment cnt[rsv_addr].
  - we==1, wr_addr!=0, cnt[wr_addr]>0: decrement cnt[wr_addr].
  - Write to a register with cnt==0: data is stored, counter stays 0 (no underflow).
  - rsv and we to the same address in the same cycle: net counter unchanged, unless the counter was 0, in which case the result is 1.
  - Increment when cnt==max: increment dropped, counter holds, ovf_err set to 1 (sticky until reset).
  - rd_busyN = (cnt[rd_addrN]!=0), combinational.
  - rd_busyN is not bypassed: a write this cycle clears busy only from the next cycle.
- Trace:
  - Registered, one-cycle latency.
  - On an edge with we==1: trace_valid<=1, trace_pc<=wr_pc, trace_addr<=wr_addr, trace_data<=wr_data. This includes wr_addr==0.
  - Otherwise trace_valid<=0 and the other trace outputs hold their values.
- Widths:
  - No arithmetic on data.
  - Counters saturate at 2**PEND_W-1 and never wrap.

Test Plan:
- Reset then read: deassert reset; read addr 5 and addr 0 -> rd_data1=0, rd_data2=0, rd_busy1/2=0, trace_valid=0.
- Write and bypass: we=1, wr_addr=3, wr_data=0xDEADBEEF, rd_addr1=3 in the same cycle -> rd_data1=0xDEADBEEF before the edge. Next cycle: stored value read back; trace_valid=1, trace_addr=3, trace_data=0xDEADBEEF, trace_pc=wr_pc.
- Register 0: we=1, wr_addr=0, wr_data=0x12345678 -> rd_data of addr 0 stays 0; trace_valid=1 with trace_addr=0, trace_data=0x12345678; a reservation rsv=1, rsv_addr=0 leaves rd_busy of addr 0 at 0.
- Scoreboard counting: reserve addr 7 twice -> rd_busy1=1; one write -> still busy; second write -> rd_busy1=0. A simultaneous rsv+we to addr 7 with cnt=1 keeps cnt=1.
- Saturation: with PEND_W=2, reserve addr 9 four times -> cnt=3, ovf_err=1; three writes -> rd_busy=0; ovf_err stays 1 until reset.
- Async reset mid-run: drive reset=0 between clock edges while regs and counters are nonzero -> all outputs 0 immediately, without waiting for an edge.
